// File: rtl/enable_sequencer.sv
// Ordered subsystem enable ramp with heartbeat watchdog,
// fault abort, reverse-order shutdown and holdoff re-ramp.
module enable_sequencer #(
   parameter int unsigned clockFreq    = 32'd80000000,
   parameter int unsigned STAGES       = 4,
   parameter int unsigned stageDelayMs = 10,
   parameter int unsigned wdtTimeoutMs = 500,
   parameter int unsigned holdoffMs    = 100,
   parameter bit          WDT_EN       = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              kick,
   input  logic              fault,
   output logic [STAGES-1:0] en,
   output logic              ready,
   output logic              wdtTrip,
   output logic [7:0]        tripCount
);

   localparam int unsigned MS = clockFreq / 1000;
   localparam logic [31:0] DM1 = 32'(stageDelayMs * MS - 1);
   localparam logic [31:0] WM1 = 32'(wdtTimeoutMs * MS - 1);
   localparam logic [31:0] HM1 = 32'(holdoffMs * MS - 1);
   localparam logic [2:0]  LAST = 3'(STAGES - 1);
   localparam logic [STAGES-1:0] ONE = 1;

   typedef enum logic [2:0] {
      IDLE, UP, RUN, DOWN, HOLD
   } state_t;

   state_t      state;
   logic [31:0] cnt;
   logic [31:0] wdt;
   logic [2:0]  stg;
   logic        f1;
   logic        fs;
   logic        abort;
   logic        timeout;
   logic [7:0]  tc_inc;

   assign abort   = fs && (state == UP || state == RUN ||
                           state == DOWN);
   assign timeout = WDT_EN && !kick && (wdt == WM1);
   assign tc_inc  = (tripCount == 8'hFF) ? tripCount
                                         : tripCount + 8'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         en        <= '0;
         ready     <= 1'b0;
         wdtTrip   <= 1'b0;
         tripCount <= '0;
         cnt       <= '0;
         wdt       <= '0;
         stg       <= '0;
         f1        <= 1'b0;
         fs        <= 1'b0;
      end else begin
         f1      <= fault;
         fs      <= f1;
         wdtTrip <= 1'b0;
         // fault outranks a same-cycle watchdog timeout
         if (abort) begin
            en        <= '0;
            ready     <= 1'b0;
            tripCount <= tc_inc;
            cnt       <= '0;
            state     <= HOLD;
         end else begin
            unique case (state)
               IDLE: begin
                  cnt   <= '0;
                  stg   <= '0;
                  state <= UP;
               end
               UP: begin
                  if (cnt == DM1) begin
                     cnt <= '0;
                     en  <= en | (ONE << stg);
                     if (stg == LAST) begin
                        ready <= 1'b1;
                        wdt   <= '0;
                        state <= RUN;
                     end else begin
                        stg <= stg + 3'd1;
                     end
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               RUN: begin
                  if (timeout) begin
                     wdtTrip   <= 1'b1;
                     tripCount <= tc_inc;
                     ready     <= 1'b0;
                     en        <= en & ~(ONE << LAST);
                     cnt       <= '0;
                     wdt       <= '0;
                     if (STAGES == 1) begin
                        state <= HOLD;
                     end else begin
                        stg   <= LAST - 3'd1;
                        state <= DOWN;
                     end
                  end else if (kick || !WDT_EN) begin
                     wdt <= '0;
                  end else begin
                     wdt <= wdt + 32'd1;
                  end
               end
               DOWN: begin
                  if (cnt == DM1) begin
                     cnt <= '0;
                     en  <= en & ~(ONE << stg);
                     if (stg == 3'd0) begin
                        state <= HOLD;
                     end else begin
                        stg <= stg - 3'd1;
                     end
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               HOLD: begin
                  en <= '0;
                  if (fs) begin
                     cnt <= '0;
                  end else if (cnt == HM1) begin
                     cnt   <= '0;
                     stg   <= '0;
                     state <= UP;
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/enable_sequencer.md
Name: enable_sequencer

Overview:
- Consumer end of the global enable: takes the power-on enable (active-low reset, low = system held) and releases a chain of subsystem enables in a fixed order with programmable spacing.
- Supervises the running system with a heartbeat watchdog and an external fault input. On a trip it drops the enables in reverse order, waits a holdoff, then re-runs the power-up ramp.
- Sits directly downstream of the global reset generator, in front of the ADC/telemetry/transmit blocks.

Parameters:
- clockFreq, 32'd80000000, clk frequency in Hz; 1 ms = MS = clockFreq/1000 cycles (integer division).
- STAGES, 4, number of enable outputs (1..8).
- stageDelayMs, 10, spacing between successive enable edges; D = stageDelayMs*MS cycles, D >= 1.
- wdtTimeoutMs, 500, heartbeat timeout; W = wdtTimeoutMs*MS cycles, W >= 2.
- holdoffMs, 100, dead time after shutdown before re-ramp; H = holdoffMs*MS cycles, H >= 1.
- WDT_EN, 1, 0 disables the watchdog (kick ignored, no trips).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset (the global enable; low = hold everything).
- kick  in  1  synchronous heartbeat; any cycle with kick=1 restarts the watchdog.
- fault  in  1  asynchronous external abort, active-high, synchronised internally by 2 FFs.
- en  out  STAGES  subsystem enables; bit 0 rises first and falls last.
- ready  out  1  high only while all enables are up and the block is in RUN.
- wdtTrip  out  1  one-cycle pulse on watchdog timeout.
- tripCount  out  8  saturating count of watchdog trips plus fault shutdowns.

Behaviour:
- Reset (rst=0, async): state IDLE, en=0, ready=0, wdtTrip=0, tripCount=0, all counters and fault sync FFs 0.
- Edges are counted from E0 = the first rising clk edge with rst=1.
- IDLE: lasts exactly one cycle. At E0 go to UP with the delay counter cleared.
- UP:
  - Delay counter counts D cycles per stage.
  - en[k] rises on edge E0 + (k+1)*D.
  - On the edge that raises en[STAGES-1]: ready=1, go to RUN, clear the watchdog counter.
  - kick is ignored in UP.
- RUN:
  - Watchdog counter increments each cycle with kick=0 and clears on any cycle with kick=1.
  - Trip condition: counter = W-1 with kick=0, which is the W-th consecutive cycle without kick. Kick on that cycle wins and there is no trip.
  - Same edge as the trip: wdtTrip=1 for one cycle, tripCount+1 (saturates at 255), ready=0, en[STAGES-1]=0, go to DOWN.
- DOWN:
  - Every D cycles the next lower enable drops.
  - en[0] drops (STAGES-1)*D cycles after the trip edge.
  - On that same edge go to HOLD.
  - For STAGES=1, go straight from the trip to HOLD.
- HOLD:
  - All en=0. Counter counts H cycles, then goes to UP. The ramp timing equals the reset ramp, with the UP entry edge as E0.
  - While synchronised fault=1 the holdoff counter is held at 0.
- Fault:
  - Synchronised fault (fault_s, 2-cycle latency) =1 in UP, RUN or DOWN causes, on that edge, en=0 (all bits at once), ready=0, tripCount+1 (saturating), go to HOLD. wdtTrip stays 0.
  - fault in IDLE or HOLD has no effect beyond holding HOLD.
  - Fault and watchdog timeout on the same cycle: fault wins; tripCount increments once only.
- WDT_EN=0: RUN is terminal except for fault.
- rst low at any time: immediate async return to the reset values. tripCount is also cleared.
- All outputs are registered; no combinational paths from inputs to outputs.

Test Plan:
Use clockFreq=1000 (MS=1), STAGES=4, stageDelayMs=10, wdtTimeoutMs=50, holdoffMs=20, so D=10, W=50, H=20.
- Release rst, kick every 20 cycles -> en = 0001/0011/0111/1111 at E0+10/20/30/40; ready=1 at E0+40; no trip for 1000 cycles.
- Stop kick after RUN entry -> wdtTrip pulses 50 cycles after the last kick cycle; en 1111->0111 at trip, 0011 at +10, 0001 at +20, 0000 at +30; tripCount=1; re-ramp en[0] at +30+20+10.
- Kick exactly on the 50th kickless cycle -> no trip; counter restarts.
- Pulse fault=1 for 3 cycles in RUN -> 2 cycles later en=0000 in one edge, wdtTrip=0, tripCount+1; hold fault high 100 cycles -> en stays 0 until fault low + 2 + 20 cycles, then ramp.
- Drop rst mid-DOWN (en=0011) -> en, ready and tripCount are 0 asynchronously; after release the full ramp restarts from en[0] at E0+10.
- Force 260 trips -> tripCount saturates at 255.
